// File: rtl/hub75_rx.sv
// HUB75 receive/snoop block: rebuilds shifted rows into column RAM writes and row-commit events.
// Optional `HUB75_RX_ON_TIME_EN adds the line_on_time output (unblanked clk cycles per row).
module hub75_rx #(
    parameter int N_BANKS    = 2,
    parameter int N_COLS     = 64,
    parameter int N_ROWS     = 32,
    parameter int N_CHANS    = 3,
    parameter int SDW        = N_BANKS * N_CHANS,
    parameter int LOG_N_COLS = $clog2(N_COLS),
    parameter int LOG_N_ROWS = $clog2(N_ROWS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  hub_clk,
    input  logic [SDW-1:0]        hub_data,
    input  logic                  hub_le,
    input  logic                  hub_blank,
    input  logic [LOG_N_ROWS-1:0] hub_addr,
    output logic [SDW-1:0]        wr_data,
    output logic [LOG_N_COLS-1:0] wr_col_addr,
    output logic                  wr_ena,
    output logic                  line_stb,
    output logic [LOG_N_ROWS-1:0] line_row,
    output logic [LOG_N_COLS:0]   line_cols,
    output logic                  line_ovf,
    output logic                  err_ovf
`ifdef HUB75_RX_ON_TIME_EN
    ,
    output logic [23:0]           line_on_time
`endif
);

    localparam int N_IN = SDW + 3 + LOG_N_ROWS;
    localparam int B_CLK = SDW;
    localparam int B_LE = SDW + 1;
    localparam int B_BLANK = SDW + 2;
    localparam logic [LOG_N_COLS:0] COLS_MAX = (LOG_N_COLS + 1)'(N_COLS);

    typedef enum logic [1:0] {
        ST_SHIFT,
        ST_COMMIT,
        ST_HOLD
    } state_t;

    logic [N_IN-1:0] in_vec;
    logic [N_IN-1:0] sync_vec;
    logic [N_IN-1:0] hist_vec;

    assign in_vec = {hub_addr, hub_blank, hub_le, hub_clk, hub_data};

    // Each input bit: two metastability flops, then a history flop for edge detection.
    generate
        for (genvar gi = 0; gi < N_IN; gi++) begin : g_sync
            logic s1_reg;
            logic s2_reg;
            logic hist_reg;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    s1_reg   <= 1'b0;
                    s2_reg   <= 1'b0;
                    hist_reg <= 1'b0;
                end else begin
                    s1_reg   <= in_vec[gi];
                    s2_reg   <= s1_reg;
                    hist_reg <= s2_reg;
                end
            end

            assign sync_vec[gi] = s2_reg;
            assign hist_vec[gi] = hist_reg;
        end
    endgenerate

    logic [SDW-1:0]        data_sync;
    logic [LOG_N_ROWS-1:0] addr_sync;
    logic                  le_sync;
    logic                  blank_sync;
    logic                  clk_rise;
    logic                  le_rise;
    logic                  unused_bits;

    assign data_sync  = sync_vec[SDW-1:0];
    assign addr_sync  = sync_vec[N_IN-1 -: LOG_N_ROWS];
    assign le_sync    = sync_vec[B_LE];
    assign blank_sync = sync_vec[B_BLANK];
    assign clk_rise   = sync_vec[B_CLK] & ~hist_vec[B_CLK];
    assign le_rise    = sync_vec[B_LE] & ~hist_vec[B_LE];

    // History bits of data/addr/blank carry no edge meaning; blank is unused without the on-time option.
    assign unused_bits = ^{hist_vec[SDW-1:0], hist_vec[N_IN-1 -: LOG_N_ROWS],
                           hist_vec[B_BLANK], blank_sync};

    state_t                state_reg;
    state_t                state_next;
    logic [LOG_N_COLS:0]   cnt_reg;
    logic                  row_ovf_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_SHIFT;
        end else begin
            state_reg <= state_next;
        end
    end

    // HOLD leaves on the synchronised latch level being low, i.e. after the hub_le fall.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_SHIFT:  if (le_rise) state_next = ST_COMMIT;
            ST_COMMIT: state_next = ST_HOLD;
            ST_HOLD:   if (!le_sync) state_next = ST_SHIFT;
            default:   state_next = ST_SHIFT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg     <= '0;
            row_ovf_reg <= 1'b0;
            wr_ena      <= 1'b0;
            wr_data     <= '0;
            wr_col_addr <= '0;
            line_stb    <= 1'b0;
            line_row    <= '0;
            line_cols   <= '0;
            line_ovf    <= 1'b0;
            err_ovf     <= 1'b0;
        end else begin
            wr_ena   <= 1'b0;
            line_stb <= 1'b0;
            // A column arriving with the latch edge is still captured and counted.
            if (state_reg == ST_SHIFT && clk_rise) begin
                if (cnt_reg < COLS_MAX) begin
                    wr_ena      <= 1'b1;
                    wr_data     <= data_sync;
                    wr_col_addr <= cnt_reg[LOG_N_COLS-1:0];
                    cnt_reg     <= cnt_reg + 1'b1;
                end else begin
                    row_ovf_reg <= 1'b1;
                    err_ovf     <= 1'b1;
                end
            end
            if (state_reg == ST_COMMIT) begin
                line_stb    <= 1'b1;
                line_row    <= addr_sync;
                line_cols   <= cnt_reg;
                line_ovf    <= row_ovf_reg;
                cnt_reg     <= '0;
                row_ovf_reg <= 1'b0;
            end
        end
    end

`ifdef HUB75_RX_ON_TIME_EN
    logic [23:0] on_cnt_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            on_cnt_reg   <= '0;
            line_on_time <= '0;
        end else if (state_reg == ST_COMMIT) begin
            line_on_time <= on_cnt_reg;
            on_cnt_reg   <= '0;
        end else if (!blank_sync && on_cnt_reg != 24'hFF_FFFF) begin
            on_cnt_reg <= on_cnt_reg + 24'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hub75_rx.sv
// Directed bench for hub75_rx: full row, overflow, empty latch, coincident edges, mid-row reset.
// Build with +define+HUB75_RX_ON_TIME_EN to also cover line_on_time.
module tb_hub75_rx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       hub_clk = 1'b0;
    logic [5:0] hub_data = '0;
    logic       hub_le = 1'b0;
    logic       hub_blank = 1'b1;
    logic [4:0] hub_addr = '0;
    logic [5:0] wr_data;
    logic [5:0] wr_col_addr;
    logic       wr_ena;
    logic       line_stb;
    logic [4:0] line_row;
    logic [6:0] line_cols;
    logic       line_ovf;
    logic       err_ovf;
`ifdef HUB75_RX_ON_TIME_EN
    logic [23:0] line_on_time;
`endif

    hub75_rx dut (
        .clk(clk),
        .rst(rst),
        .hub_clk(hub_clk),
        .hub_data(hub_data),
        .hub_le(hub_le),
        .hub_blank(hub_blank),
        .hub_addr(hub_addr),
        .wr_data(wr_data),
        .wr_col_addr(wr_col_addr),
        .wr_ena(wr_ena),
        .line_stb(line_stb),
        .line_row(line_row),
        .line_cols(line_cols),
        .line_ovf(line_ovf),
        .err_ovf(err_ovf)
`ifdef HUB75_RX_ON_TIME_EN
        ,
        .line_on_time(line_on_time)
`endif
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    // Monitor: cumulative counts so tests work on differences.
    int         wr_cnt = 0;
    int         bad_cnt = 0;
    int         stb_cnt = 0;
    logic [5:0] last_addr = '0;
    logic [5:0] last_data = '0;
    logic [4:0] stb_row = '0;
    logic [6:0] stb_cols = '0;
    logic       stb_ovf = 1'b0;

    always @(negedge clk) begin
        if (wr_ena) begin
            wr_cnt++;
            last_addr = wr_col_addr;
            last_data = wr_data;
            if (wr_data != wr_col_addr) bad_cnt++;
        end
        if (line_stb) begin
            stb_cnt++;
            stb_row  = line_row;
            stb_cols = line_cols;
            stb_ovf  = line_ovf;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s = %0d", tag, got);
        end
    endtask

    // One panel clock at clk/8 carrying column data d.
    task automatic hub_pulse(input logic [5:0] d);
        hub_data = d;
        #40 hub_clk = 1'b1;
        #40 hub_clk = 1'b0;
    endtask

    task automatic hub_latch(input logic [4:0] a);
        hub_addr = a;
        #40 hub_le = 1'b1;
        #80 hub_le = 1'b0;
        #80;
    endtask

    int w0, b0, s0;

    task automatic mark();
        w0 = wr_cnt;
        b0 = bad_cnt;
        s0 = stb_cnt;
    endtask

    initial begin
        #30 rst = 1'b0;
        #40;
        check("reset_line_cols", 32'(line_cols), 32'd0);
        check("reset_err_ovf", 32'(err_ovf), 32'd0);

        // Full 64-column row.
        mark();
        for (int i = 0; i < 64; i++) hub_pulse(6'(i));
        hub_latch(5'd5);
        check("t1_writes", 32'(wr_cnt - w0), 32'd64);
        check("t1_addr_data", 32'(bad_cnt - b0), 32'd0);
        check("t1_last_addr", 32'(last_addr), 32'd63);
        check("t1_stb_count", 32'(stb_cnt - s0), 32'd1);
        check("t1_line_row", 32'(stb_row), 32'd5);
        check("t1_line_cols", 32'(stb_cols), 32'd64);
        check("t1_line_ovf", 32'(stb_ovf), 32'd0);
        check("t1_err_ovf", 32'(err_ovf), 32'd0);

        // Overflow: 70 clocks, only 64 written.
        mark();
        for (int i = 0; i < 70; i++) hub_pulse(6'(i));
        hub_latch(5'd7);
        check("t2_writes", 32'(wr_cnt - w0), 32'd64);
        check("t2_addr_data", 32'(bad_cnt - b0), 32'd0);
        check("t2_line_cols", 32'(stb_cols), 32'd64);
        check("t2_line_ovf", 32'(stb_ovf), 32'd1);
        check("t2_err_ovf", 32'(err_ovf), 32'd1);
        mark();
        for (int i = 0; i < 5; i++) hub_pulse(6'(i));
        hub_latch(5'd8);
        check("t2_clean_cols", 32'(stb_cols), 32'd5);
        check("t2_clean_ovf", 32'(stb_ovf), 32'd0);
        check("t2_err_sticky", 32'(err_ovf), 32'd1);

        // Empty latch.
        mark();
        hub_latch(5'd31);
        check("t3_stb_count", 32'(stb_cnt - s0), 32'd1);
        check("t3_line_cols", 32'(stb_cols), 32'd0);
        check("t3_line_row", 32'(stb_row), 32'd31);
        check("t3_writes", 32'(wr_cnt - w0), 32'd0);
        #200;
        check("t3_hold_row", 32'(line_row), 32'd31);

        // Coincident hub_clk and hub_le rise after 10 columns.
        mark();
        for (int i = 0; i < 10; i++) hub_pulse(6'(i));
        hub_addr = 5'd12;
        hub_data = 6'd10;
        #40;
        hub_clk = 1'b1;
        hub_le  = 1'b1;
        #40 hub_clk = 1'b0;
        #40 hub_le = 1'b0;
        #80;
        check("t4_writes", 32'(wr_cnt - w0), 32'd11);
        check("t4_last_addr", 32'(last_addr), 32'd10);
        check("t4_last_data", 32'(last_data), 32'd10);
        check("t4_line_cols", 32'(stb_cols), 32'd11);
        check("t4_stb_count", 32'(stb_cnt - s0), 32'd1);

        // Reset mid-row.
        mark();
        for (int i = 0; i < 20; i++) hub_pulse(6'(i));
        rst = 1'b1;
        #20;
        check("t5_rst_wr_ena", 32'(wr_ena), 32'd0);
        check("t5_rst_line_cols", 32'(line_cols), 32'd0);
        check("t5_rst_line_row", 32'(line_row), 32'd0);
        check("t5_rst_err_ovf", 32'(err_ovf), 32'd0);
        #20 rst = 1'b0;
        #40;
        for (int i = 0; i < 64; i++) hub_pulse(6'(i));
        hub_latch(5'd3);
        check("t5_stb_count", 32'(stb_cnt - s0), 32'd1);
        check("t5_line_cols", 32'(stb_cols), 32'd64);
        check("t5_line_row", 32'(stb_row), 32'd3);
        check("t5_err_ovf", 32'(err_ovf), 32'd0);

`ifdef HUB75_RX_ON_TIME_EN
        // 1000 unblanked clk cycles between two latches.
        hub_latch(5'd1);
        hub_blank = 1'b0;
        #10000 hub_blank = 1'b1;
        #40;
        hub_latch(5'd2);
        check("t6_on_time_in_range",
              32'((line_on_time >= 24'd999) && (line_on_time <= 24'd1001)), 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
